usart_host_ctrl: RTL and testbench

Register-bus master that configures one USARTn instance after reset and then schedules all traffic to it. It arbitrates between two transmit requesters and drains received characters. It drives the USART's ram_Addr/ramwe/ramre/dbus_in bus and samples its dbus_out, so no CPU is needed for UART traffic. It sits between the USARTn register port and two on-chip byte producers plus one byte consumer.

---
 rtl/usart_host_ctrl_if.sv | 19 +
 rtl/usart_host_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_usart_host_ctrl.sv | 537 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usart_host_ctrl_if.sv
// Register-port bundle between the host controller and one USARTn instance.
// The controller is the master; the USART register file is the slave.
interface usart_host_ctrl_if;
  logic [11:0] u_ram_Addr;
  logic        u_ramwe;
  logic        u_ramre;
  logic [7:0]  u_dbus_in;
  logic [7:0]  u_dbus_out;

  modport master (
    output u_ram_Addr, u_ramwe, u_ramre, u_dbus_in,
    input  u_dbus_out
  );

  modport slave (
    input  u_ram_Addr, u_ramwe, u_ramre, u_dbus_in,
    output u_dbus_out
  );
endinterface

// File: rtl/usart_host_ctrl.sv
// Configures a USARTn after reset, then polls UCSRnA forever, draining RX
// first and round-robin arbitrating two TX byte producers into UDRn.
module usart_host_ctrl #(
  parameter logic [11:0] UBRR_VAL  = 12'd129,
  parameter logic [7:0]  UCSRA_VAL = 8'h00,
  parameter logic [7:0]  UCSRB_VAL = 8'h18,
  parameter logic [7:0]  UCSRC_VAL = 8'h06
) (
  input  logic              cp2,
  input  logic              ireset,
  usart_host_ctrl_if.master bus,
  output logic              cfg_done,
  input  logic              tx0_req,
  input  logic              tx1_req,
  input  logic [7:0]        tx0_data,
  input  logic [7:0]        tx1_data,
  output logic              tx0_ack,
  output logic              tx1_ack,
  output logic [7:0]        rx_data,
  output logic [2:0]        rx_err,
  output logic              rx_valid
);

  localparam logic [3:0] S_CFG0 = 4'd0;
  localparam logic [3:0] S_CFG1 = 4'd1;
  localparam logic [3:0] S_CFG2 = 4'd2;
  localparam logic [3:0] S_CFG3 = 4'd3;
  localparam logic [3:0] S_CFG4 = 4'd4;
  localparam logic [3:0] S_POLL = 4'd5;
  localparam logic [3:0] S_DEC  = 4'd6;
  localparam logic [3:0] S_RXRD = 4'd7;
  localparam logic [3:0] S_TXWR = 4'd8;

  localparam logic [11:0] A_UCSRA = 12'h0C0;
  localparam logic [11:0] A_UCSRB = 12'h0C1;
  localparam logic [11:0] A_UCSRC = 12'h0C2;
  localparam logic [11:0] A_UBRRL = 12'h0C4;
  localparam logic [11:0] A_UBRRH = 12'h0C5;
  localparam logic [11:0] A_UDR   = 12'h0C6;

  logic [3:0] state_q, state_d;
  logic       active_q, active_d;
  logic       st_rxc_q, st_rxc_d;
  logic       st_udre_q, st_udre_d;
  logic [2:0] st_err_q, st_err_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       cfg_done_q, cfg_done_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] rx_err_q, rx_err_d;
  logic       rx_valid_q, rx_valid_d;
  logic       arb_sel;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  assign arb_sel = (tx0_req && tx1_req) ? ~last_grant_q : tx1_req;

  always_comb begin
    state_d      = state_q;
    active_d     = 1'b1;
    st_rxc_d     = st_rxc_q;
    st_udre_d    = st_udre_q;
    st_err_d     = st_err_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cfg_done_d   = cfg_done_q;
    rx_data_d    = rx_data_q;
    rx_err_d     = rx_err_q;
    rx_valid_d   = 1'b0;
    if (active_q) begin
      case (state_q)
        S_CFG0: state_d = S_CFG1;
        S_CFG1: state_d = S_CFG2;
        S_CFG2: state_d = S_CFG3;
        S_CFG3: state_d = S_CFG4;
        S_CFG4: begin
          state_d    = S_POLL;
          cfg_done_d = 1'b1;
        end
        S_POLL: begin
          st_rxc_d  = bus.u_dbus_out[7];
          st_udre_d = bus.u_dbus_out[5];
          st_err_d  = bus.u_dbus_out[4:2];
          state_d   = S_DEC;
        end
        S_DEC: begin
          // Receive first so a pending character is never overrun by TX work.
          if (st_rxc_q) begin
            state_d = S_RXRD;
          end else if (st_udre_q && (tx0_req || tx1_req)) begin
            state_d = S_TXWR;
            grant_d = arb_sel;
          end else begin
            state_d = S_POLL;
          end
        end
        S_RXRD: begin
          rx_data_d  = bus.u_dbus_out;
          rx_err_d   = st_err_q;
          rx_valid_d = 1'b1;
          state_d    = S_POLL;
        end
        S_TXWR: begin
          last_grant_d = grant_q;
          state_d      = S_POLL;
        end
        default: state_d = S_CFG0;
      endcase
    end
  end

  // Bus strobes decode straight from the state so an async reset kills them at once;
  // active_q holds the bus quiet until the first edge after release.
  always_comb begin
    bus.u_ram_Addr = 12'h000;
    bus.u_ramwe    = 1'b0;
    bus.u_ramre    = 1'b0;
    bus.u_dbus_in  = 8'h00;
    tx0_ack        = 1'b0;
    tx1_ack        = 1'b0;
    if (active_q) begin
      case (state_q)
        S_CFG0: begin
          bus.u_ram_Addr = A_UBRRH;
          bus.u_ramwe    = 1'b1;
          bus.u_dbus_in  = {4'b0000, UBRR_VAL[11:8]};
        end
        S_CFG1: begin
          bus.u_ram_Addr = A_UBRRL;
          bus.u_ramwe    = 1'b1;
          bus.u_dbus_in  = UBRR_VAL[7:0];
        end
        S_CFG2: begin
          bus.u_ram_Addr = A_UCSRA;
          bus.u_ramwe    = 1'b1;
          bus.u_dbus_in  = UCSRA_VAL;
        end
        S_CFG3: begin
          bus.u_ram_Addr = A_UCSRC;
          bus.u_ramwe    = 1'b1;
          bus.u_dbus_in  = UCSRC_VAL;
        end
        S_CFG4: begin
          bus.u_ram_Addr = A_UCSRB;
          bus.u_ramwe    = 1'b1;
          bus.u_dbus_in  = UCSRB_VAL;
        end
        S_POLL: begin
          bus.u_ram_Addr = A_UCSRA;
          bus.u_ramre    = 1'b1;
        end
        S_RXRD: begin
          bus.u_ram_Addr = A_UDR;
          bus.u_ramre    = 1'b1;
        end
        S_TXWR: begin
          bus.u_ram_Addr = A_UDR;
          bus.u_ramwe    = 1'b1;
          bus.u_dbus_in  = grant_q ? tx1_data : tx0_data;
          tx0_ack        = ~grant_q;
          tx1_ack        = grant_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q      <= S_CFG0;
      active_q     <= 1'b0;
      st_rxc_q     <= 1'b0;
      st_udre_q    <= 1'b0;
      st_err_q     <= 3'b000;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cfg_done_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_err_q     <= 3'b000;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      st_rxc_q     <= st_rxc_d;
      st_udre_q    <= st_udre_d;
      st_err_q     <= st_err_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cfg_done_q   <= cfg_done_d;
      rx_data_q    <= rx_data_d;
      rx_err_q     <= rx_err_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign cfg_done = cfg_done_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_usart_host_ctrl.sv
// Bench for usart_host_ctrl: a small USART register model answers reads,
// a monitor logs bus cycles, and scenario tasks score them against queues.
module tb_usart_host_ctrl;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        we;
    logic        ack0;
    logic        ack1;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [2:0] err;
  } rx_ev_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        ack0;
    logic        ack1;
  } wr_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] err;
  } rx_t;

  logic       cp2 = 1'b0;
  logic       ireset = 1'b0;
  logic       tx0_req = 1'b0, tx1_req = 1'b0;
  logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
  logic       tx0_ack, tx1_ack, cfg_done, rx_valid;
  logic [7:0] rx_data;
  logic [2:0] rx_err;
  logic [7:0] status_m = 8'h00;
  logic [7:0] rx_byte_m = 8'h00;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int both_cnt = 0;
  int leak_cnt = 0;

  ev_t    ev_q[$];
  rx_ev_t rxe_q[$];
  wr_t    exp_wr[$];
  rx_t    exp_rx[$];

  usart_host_ctrl_if bif();

  // USART register model: UCSRnA and UDRn readable, everything else reads 0.
  assign bif.u_dbus_out = (bif.u_ramre && bif.u_ram_Addr == 12'h0C0) ? status_m :
                          (bif.u_ramre && bif.u_ram_Addr == 12'h0C6) ? rx_byte_m : 8'h00;

  usart_host_ctrl dut (
    .cp2      (cp2),
    .ireset   (ireset),
    .bus      (bif),
    .cfg_done (cfg_done),
    .tx0_req  (tx0_req),
    .tx1_req  (tx1_req),
    .tx0_data (tx0_data),
    .tx1_data (tx1_data),
    .tx0_ack  (tx0_ack),
    .tx1_ack  (tx1_ack),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .rx_valid (rx_valid)
  );

  always #5 cp2 = ~cp2;

  always @(posedge cp2) cyc <= cyc + 1;

  always @(negedge cp2) begin
    if (bif.u_ramwe || bif.u_ramre)
      ev_q.push_back('{cyc, bif.u_ram_Addr, bif.u_dbus_in, bif.u_ramwe, tx0_ack, tx1_ack});
    if (rx_valid)
      rxe_q.push_back('{cyc, rx_data, rx_err});
    if (bif.u_ramwe && bif.u_ramre)
      both_cnt <= both_cnt + 1;
    if (!bif.u_ramwe && bif.u_dbus_in !== 8'h00)
      leak_cnt <= leak_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge cp2);
    #1;
  endtask

  // Releases reset (caller holds it low, at negedge+1) and scores the 5 config writes.
  task automatic test_cfg_sequence();
    int  rel;
    int  n;
    ev_t e;
    wr_t x;
    x = {12'h0C5, 8'h00, 1'b0, 1'b0}; exp_wr.push_back(x);
    x = {12'h0C4, 8'h81, 1'b0, 1'b0}; exp_wr.push_back(x);
    x = {12'h0C0, 8'h00, 1'b0, 1'b0}; exp_wr.push_back(x);
    x = {12'h0C2, 8'h06, 1'b0, 1'b0}; exp_wr.push_back(x);
    x = {12'h0C1, 8'h18, 1'b0, 1'b0}; exp_wr.push_back(x);
    ev_q.delete();
    ireset = 1'b1;
    rel = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cyc == rel + 5) begin
        checks++;
        if (cfg_done !== 1'b0) begin
          failures++;
          $display("FAIL cfg_done_early: got %b want 0", cfg_done);
        end
      end
      if (cyc == rel + 6) begin
        checks++;
        if (cfg_done !== 1'b1) begin
          failures++;
          $display("FAIL cfg_done_rise: got %b want 1", cfg_done);
        end
      end
    end
    n = 0;
    while (ev_q.size() > 0 && n < 7) begin
      e = ev_q.pop_front();
      checks++;
      if (n < 5) begin
        x = exp_wr.pop_front();
        if (e.we !== 1'b1 || e.addr !== x.addr || e.data !== x.data || e.cyc != rel + 1 + n) begin
          failures++;
          $display("FAIL cfg_write[%0d]: got we=%b addr=%h data=%h cyc=+%0d want we=1 addr=%h data=%h cyc=+%0d",
                   n, e.we, e.addr, e.data, e.cyc - rel, x.addr, x.data, 1 + n);
        end
      end else begin
        if (e.we !== 1'b0 || e.addr !== 12'h0C0 || e.cyc != rel + 6 + 2 * (n - 5)) begin
          failures++;
          $display("FAIL poll_read[%0d]: got we=%b addr=%h cyc=+%0d want read addr=0c0 cyc=+%0d",
                   n - 5, e.we, e.addr, e.cyc - rel, 6 + 2 * (n - 5));
        end
      end
      n++;
    end
    checks++;
    if (n != 7) begin
      failures++;
      $display("FAIL cfg_event_count: got %0d want 7", n);
    end
    exp_wr.delete();
  endtask

  task automatic test_reset();
    ireset = 1'b0;
    repeat (3) tick();
    checks++;
    if (bif.u_ramwe !== 1'b0 || bif.u_ramre !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: got we=%b re=%b want 0 0", bif.u_ramwe, bif.u_ramre);
    end
    checks++;
    if (bif.u_ram_Addr !== 12'h000 || bif.u_dbus_in !== 8'h00) begin
      failures++;
      $display("FAIL reset_bus: got addr=%h din=%h want 000 00", bif.u_ram_Addr, bif.u_dbus_in);
    end
    checks++;
    if (cfg_done !== 1'b0 || tx0_ack !== 1'b0 || tx1_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got cfg_done=%b ack0=%b ack1=%b want 0 0 0", cfg_done, tx0_ack, tx1_ack);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_err !== 3'b000) begin
      failures++;
      $display("FAIL reset_rx: got valid=%b data=%h err=%b want 0 00 000", rx_valid, rx_data, rx_err);
    end
    test_cfg_sequence();
  endtask

  task automatic test_round_robin();
    ev_t e;
    wr_t x;
    int  got;
    int  last_cyc;
    got = 0;
    last_cyc = 0;
    status_m = 8'h20;
    tx0_data = 8'hA1;
    tx1_data = 8'hB2;
    for (int k = 0; k < 4; k++) begin
      x = (k % 2 == 0) ? {12'h0C6, 8'hA1, 1'b1, 1'b0} : {12'h0C6, 8'hB2, 1'b0, 1'b1};
      exp_wr.push_back(x);
    end
    ev_q.delete();
    tx0_req = 1'b1;
    tx1_req = 1'b1;
    for (int i = 0; i < 40 && got < 4; i++) begin
      tick();
      while (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        if (e.we && got < 4) begin
          x = exp_wr.pop_front();
          checks++;
          if (e.addr !== x.addr || e.data !== x.data || e.ack0 !== x.ack0 || e.ack1 !== x.ack1) begin
            failures++;
            $display("FAIL rr_write[%0d]: got addr=%h data=%h ack0=%b ack1=%b want addr=%h data=%h ack0=%b ack1=%b",
                     got, e.addr, e.data, e.ack0, e.ack1, x.addr, x.data, x.ack0, x.ack1);
          end
          if (got > 0) begin
            checks++;
            if (e.cyc - last_cyc != 3) begin
              failures++;
              $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", got, e.cyc - last_cyc);
            end
          end
          last_cyc = e.cyc;
          got++;
          if (got == 4) begin
            tx0_req = 1'b0;
            tx1_req = 1'b0;
          end
        end
      end
    end
    tx0_req = 1'b0;
    tx1_req = 1'b0;
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL rr_count: got %0d writes want 4", got);
    end
    tick();
    checks++;
    if (tx0_ack !== 1'b0 || tx1_ack !== 1'b0) begin
      failures++;
      $display("FAIL rr_ack_pulse: got ack0=%b ack1=%b want 0 0", tx0_ack, tx1_ack);
    end
    exp_wr.delete();
  endtask

  task automatic test_tx_single();
    ev_t e;
    wr_t x;
    int  t0;
    bit  seen;
    seen = 0;
    status_m = 8'h20;
    tx0_data = 8'h65;
    x = {12'h0C6, 8'h65, 1'b1, 1'b0};
    exp_wr.push_back(x);
    ev_q.delete();
    tx0_req = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      while (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        if (e.we && !seen) begin
          seen = 1;
          tx0_req = 1'b0;
          x = exp_wr.pop_front();
          checks++;
          if (e.addr !== x.addr || e.data !== x.data || e.ack0 !== x.ack0 || e.ack1 !== x.ack1) begin
            failures++;
            $display("FAIL tx0_write: got addr=%h data=%h ack0=%b ack1=%b want addr=%h data=%h ack0=%b ack1=%b",
                     e.addr, e.data, e.ack0, e.ack1, x.addr, x.data, x.ack0, x.ack1);
          end
          checks++;
          if (e.cyc - t0 > 4) begin
            failures++;
            $display("FAIL tx0_latency: got %0d cycles want <= 4", e.cyc - t0);
          end
        end
      end
    end
    tx0_req = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL tx0_timeout: got no UDRn write want one");
    end
    tick();
    checks++;
    if (tx0_ack !== 1'b0) begin
      failures++;
      $display("FAIL tx0_ack_pulse: got %b want 0", tx0_ack);
    end
    exp_wr.delete();
  endtask

  task automatic test_udre_block();
    ev_t e;
    wr_t x;
    int  wr_cnt;
    int  ack_cnt;
    bit  seen;
    wr_cnt = 0;
    ack_cnt = 0;
    seen = 0;
    status_m = 8'h00;
    tx1_data = 8'h99;
    ev_q.delete();
    tx1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx0_ack || tx1_ack) ack_cnt++;
      while (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        if (e.we) wr_cnt++;
      end
    end
    checks++;
    if (wr_cnt != 0 || ack_cnt != 0) begin
      failures++;
      $display("FAIL udre_block: got writes=%0d acks=%0d want 0 0", wr_cnt, ack_cnt);
    end
    status_m = 8'h20;
    x = {12'h0C6, 8'h99, 1'b0, 1'b1};
    exp_wr.push_back(x);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      while (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        if (e.we && !seen) begin
          seen = 1;
          tx1_req = 1'b0;
          x = exp_wr.pop_front();
          checks++;
          if (e.addr !== x.addr || e.data !== x.data || e.ack0 !== x.ack0 || e.ack1 !== x.ack1) begin
            failures++;
            $display("FAIL udre_release: got addr=%h data=%h ack0=%b ack1=%b want addr=%h data=%h ack0=%b ack1=%b",
                     e.addr, e.data, e.ack0, e.ack1, x.addr, x.data, x.ack0, x.ack1);
          end
        end
      end
    end
    tx1_req = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL udre_release_timeout: got no write want one");
    end
    exp_wr.delete();
  endtask

  task automatic test_rx_priority();
    ev_t    e;
    rx_ev_t r;
    wr_t    x;
    rx_t    y;
    bit     rd_seen;
    bit     wr_seen;
    bit     rx_seen;
    int     rd_cyc;
    rd_seen = 0;
    wr_seen = 0;
    rx_seen = 0;
    rd_cyc = 0;
    rx_byte_m = 8'h55;
    tx1_data = 8'h3C;
    x = {12'h0C6, 8'h3C, 1'b0, 1'b1};
    exp_wr.push_back(x);
    y = {8'h55, 3'b000};
    exp_rx.push_back(y);
    ev_q.delete();
    rxe_q.delete();
    status_m = 8'hA0;
    tx1_req = 1'b1;
    for (int i = 0; i < 30 && !(wr_seen && rx_seen); i++) begin
      tick();
      while (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        if (!e.we && e.addr == 12'h0C6 && !rd_seen) begin
          rd_seen = 1;
          rd_cyc = e.cyc;
          status_m = 8'h20;
        end else if (e.we && !wr_seen) begin
          wr_seen = 1;
          tx1_req = 1'b0;
          checks++;
          if (!rd_seen) begin
            failures++;
            $display("FAIL rx_priority_order: got TX write before UDRn read want read first");
          end
          x = exp_wr.pop_front();
          checks++;
          if (e.addr !== x.addr || e.data !== x.data || e.ack0 !== x.ack0 || e.ack1 !== x.ack1) begin
            failures++;
            $display("FAIL rx_priority_tx: got addr=%h data=%h ack0=%b ack1=%b want addr=%h data=%h ack0=%b ack1=%b",
                     e.addr, e.data, e.ack0, e.ack1, x.addr, x.data, x.ack0, x.ack1);
          end
        end
      end
      while (rxe_q.size() > 0 && !rx_seen) begin
        r = rxe_q.pop_front();
        rx_seen = 1;
        y = exp_rx.pop_front();
        checks++;
        if (r.data !== y.data || r.err !== y.err) begin
          failures++;
          $display("FAIL rx_priority_rx: got data=%h err=%b want data=%h err=%b", r.data, r.err, y.data, y.err);
        end
        checks++;
        if (!rd_seen || r.cyc != rd_cyc + 1) begin
          failures++;
          $display("FAIL rx_valid_timing: got cyc=%0d want %0d", r.cyc, rd_cyc + 1);
        end
      end
    end
    tx1_req = 1'b0;
    checks++;
    if (!wr_seen || !rx_seen) begin
      failures++;
      $display("FAIL rx_priority_timeout: got write=%b rx=%b want 1 1", wr_seen, rx_seen);
    end
    exp_wr.delete();
    exp_rx.delete();
  endtask

  task automatic test_rx_err();
    ev_t    e;
    rx_ev_t r;
    rx_t    y;
    bit     rx_seen;
    rx_seen = 0;
    rx_byte_m = 8'h77;
    y = {8'h77, 3'b110};
    exp_rx.push_back(y);
    ev_q.delete();
    rxe_q.delete();
    status_m = 8'h98;
    for (int i = 0; i < 20 && !rx_seen; i++) begin
      tick();
      while (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        if (!e.we && e.addr == 12'h0C6) status_m = 8'h00;
      end
      while (rxe_q.size() > 0 && !rx_seen) begin
        r = rxe_q.pop_front();
        rx_seen = 1;
        y = exp_rx.pop_front();
        checks++;
        if (r.data !== y.data || r.err !== y.err) begin
          failures++;
          $display("FAIL rx_err_capture: got data=%h err=%b want data=%h err=%b", r.data, r.err, y.data, y.err);
        end
      end
    end
    status_m = 8'h00;
    checks++;
    if (!rx_seen) begin
      failures++;
      $display("FAIL rx_err_timeout: got no rx_valid want one");
    end
    exp_rx.delete();
  endtask

  task automatic test_reset_mid_tx();
    wr_t x;
    bit  hit;
    hit = 0;
    status_m = 8'h20;
    tx0_data = 8'h42;
    x = {12'h0C6, 8'h42, 1'b1, 1'b0};
    exp_wr.push_back(x);
    tx0_req = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (bif.u_ramwe === 1'b1 && bif.u_ram_Addr === 12'h0C6) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_tx_timeout: got no TXWR cycle want one");
    end else begin
      x = exp_wr.pop_front();
      if (bif.u_dbus_in !== x.data || tx0_ack !== x.ack0 || tx1_ack !== x.ack1) begin
        failures++;
        $display("FAIL mid_tx_write: got data=%h ack0=%b ack1=%b want data=%h ack0=%b ack1=%b",
                 bif.u_dbus_in, tx0_ack, tx1_ack, x.data, x.ack0, x.ack1);
      end
    end
    #1;
    ireset = 1'b0;
    #1;
    checks++;
    if (tx0_ack !== 1'b0 || bif.u_ramwe !== 1'b0 || bif.u_ramre !== 1'b0 || bif.u_dbus_in !== 8'h00) begin
      failures++;
      $display("FAIL mid_tx_async_drop: got ack0=%b we=%b re=%b din=%h want 0 0 0 00",
               tx0_ack, bif.u_ramwe, bif.u_ramre, bif.u_dbus_in);
    end
    checks++;
    if (cfg_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_tx_cfg_done: got %b want 0", cfg_done);
    end
    tx0_req = 1'b0;
    status_m = 8'h00;
    exp_wr.delete();
    tick();
    tick();
    test_cfg_sequence();
  endtask

  task automatic test_bus_rules();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL strobe_exclusive: got %0d cycles with we and re high want 0", both_cnt);
    end
    checks++;
    if (leak_cnt != 0) begin
      failures++;
      $display("FAIL din_idle_zero: got %0d cycles with din!=0 while we=0 want 0", leak_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_tx_single();
    test_udre_block();
    test_rx_priority();
    test_rx_err();
    test_reset_mid_tx();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
